flex_pts_tx: RTL and testbench
==============================

Name: flex_pts_tx

Overview:
- Parametrised parallel-to-serial framed transmitter. It is the successor of the team's plain flex PTS shift register.
- Accepts a NUM_BITS word through a valid/ready handshake.
- Shifts the word out, one bit per shift_enable tick, as a frame: start bit, data (MSB- or LSB-first), optional parity bit, stop bit.
- Sits in front of the serial line driver, downstream of the TX FIFO.

Parameters:
- NUM_BITS, 8, data bits per frame (2..32).
- SHIFT_MSB, 1, 1 = MSB first, 0 = LSB first.
- PARITY_EN, 0, 1 = insert parity bit after the data.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN = 0.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- shift_enable  input  1  bit-period tick, one-cycle pulse.
- load_valid  input  1  parallel_in is valid.
- load_ready  output  1  block can accept a word.
- parallel_in  input  NUM_BITS  word to transmit.
- serial_out  output  1  serial line; idles high.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (n_rst): n_rst low forces the block to its reset state immediately, without waiting for a clock edge.
- Reset values: state = IDLE, serial_out = 1, busy = 0, frame_done = 0, shift register = 0, bit count = 0, parity latch = 0.
- Outputs: serial_out, frame_done and all state are registered. load_ready = (state == IDLE). busy = !load_ready.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Load is accepted when load_valid && load_ready.
  - On that edge: latch parallel_in, latch parity = ^parallel_in XOR PARITY_ODD, serial_out <= 0, state <= START.
  - shift_enable is ignored in IDLE.
  - If a load and a tick occur in the same cycle, the load is taken and the tick is discarded.
- START: on tick, serial_out <= first data bit (MSB if SHIFT_MSB, else LSB), count <= 0, state <= DATA.
- DATA: on tick:
  - If count == NUM_BITS-1: go to PARITY with serial_out <= parity if PARITY_EN; otherwise go to STOP with serial_out <= 1.
  - Else: shift the register toward the output end, count++, and drive the next bit.
- PARITY: on tick, serial_out <= 1, state <= STOP.
- STOP: on tick, state <= IDLE and frame_done <= 1 for exactly one cycle. serial_out stays 1.
- Bit timing: each frame bit is held from one tick to the next. With no ticks, serial_out holds indefinitely (stall-safe).
- Frame length: 1 + NUM_BITS + PARITY_EN + 1 ticks after the load edge.
- Back-to-back frames: load_ready rises in the same cycle frame_done is high. A load accepted in that cycle starts the next frame, with its start bit on the following edge.
- load_valid while busy: no effect. The word is not consumed (load_ready = 0).
- Reset mid-frame: line returns to 1 at once and the frame is abandoned. frame_done is not pulsed.
- Counter width: max(1, $clog2(NUM_BITS)). The counter never wraps past NUM_BITS-1.

Decomposition:
- Package flex_pts_pkg holds:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - localparam IDLE_LINE = 1'b1.
- Sub-module: flex_counter is the bit counter.
  - Parametrised width.
  - Inputs: clear, count_enable, rollover_val = NUM_BITS-1.
  - Output: rollover_flag, which drives the DATA exit.

Test Plan:
- LSB-first, even parity (NUM_BITS=8, SHIFT_MSB=0, PARITY_EN=1, PARITY_ODD=0): load 8'h01, then 11 ticks.
  - Required sampled serial_out: 0, 1,0,0,0,0,0,0,0, 1, 1.
  - frame_done is high exactly once, in the cycle after the 11th tick.
- MSB-first, no parity (SHIFT_MSB=1, PARITY_EN=0): load 8'h01.
  - Required serial_out: 0, 0,0,0,0,0,0,0,1, 1.
  - Frame is 10 ticks; busy is high throughout.
- Odd parity (PARITY_ODD=1): load 8'hA5 (four ones).
  - Parity bit must be 1. Then load 8'h01; parity bit must be 0.
- Back-to-back: hold load_valid high with 8'h55 then 8'hAA.
  - Second word is accepted in the frame_done cycle.
  - Only one idle-high cycle precedes the second start bit.
  - No word is dropped or duplicated.
- Busy load and stall: during DATA, pulse load_valid with 8'hFF and hold shift_enable low for 50 cycles.
  - load_ready stays 0, serial_out holds its bit, and 8'hFF is never transmitted.
- Reset mid-frame: assert n_rst after the 3rd data bit.
  - serial_out = 1 and busy = 0 immediately, with no frame_done pulse.
  - After release, load_ready = 1 and a new 8'h3C frame transmits correctly.

Source files
------------

// File: rtl/flex_pts_pkg.sv
// Shared types for the framed parallel-to-serial transmitter.
//   tx_state_t : frame state encoding used by flex_pts_tx
//   IDLE_LINE  : level of the serial line between frames
package flex_pts_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic IDLE_LINE = 1'b1;

endpackage

// File: rtl/flex_counter.sv
// Bit counter for the transmitter's data phase.
// Ports:
//   clk, n_rst      : clock, asynchronous active-low reset
//   clear           : synchronous clear to zero (priority over count_enable)
//   count_enable    : advance by one unless already at rollover_val
//   rollover_val    : terminal count
//   rollover_flag   : high while the count equals rollover_val
module flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic             rollover_flag
);

    logic [WIDTH-1:0] count;

    // Saturates at the terminal count; the owner clears it before reuse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_enable && !rollover_flag) begin
            count <= count + 1'b1;
        end
    end

    assign rollover_flag = (count == rollover_val);

endmodule

// File: rtl/flex_pts_tx.sv
// Framed parallel-to-serial transmitter: start bit, NUM_BITS data bits
// (MSB- or LSB-first), optional parity bit, stop bit. One frame bit per
// shift_enable tick; the line holds its level between ticks.
// Ports:
//   clk, n_rst     : clock, asynchronous active-low reset
//   shift_enable   : bit-period tick
//   load_valid     : parallel_in holds a word to send
//   load_ready     : block is idle and will take the word
//   parallel_in    : word to transmit
//   serial_out     : serial line, idles high
//   busy           : frame in progress
//   frame_done     : one-cycle pulse when the stop bit period ends
//
// state  | meaning
// IDLE   | line high, waiting for a word
// START  | start bit (0) on the line
// DATA   | data bits on the line, counter tracks position
// PARITY | parity bit on the line
// STOP   | stop bit (1) on the line
module flex_pts_tx
    import flex_pts_pkg::*;
#(
    parameter int NUM_BITS   = 8,
    parameter int SHIFT_MSB  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [NUM_BITS-1:0] parallel_in,
    output logic                serial_out,
    output logic                busy,
    output logic                frame_done
);

    localparam int              CW       = ($clog2(NUM_BITS) > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [CW-1:0]   LAST_BIT = CW'(NUM_BITS - 1);
    localparam logic            MSB_FIRST = (SHIFT_MSB != 0);
    localparam logic            ODD_BIT   = (PARITY_ODD != 0);

    tx_state_t           state;
    logic [NUM_BITS-1:0] shift_reg;
    logic [NUM_BITS-1:0] shifted;
    logic                parity;
    logic                first_bit;
    logic                next_bit;
    logic                cnt_clear;
    logic                cnt_en;
    logic                last_bit;

    // The output end of the register is the MSB or LSB; shifting moves
    // the following bit into that position.
    assign first_bit = MSB_FIRST ? shift_reg[NUM_BITS-1] : shift_reg[0];
    assign next_bit  = MSB_FIRST ? shift_reg[NUM_BITS-2] : shift_reg[1];
    assign shifted   = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);

    assign cnt_clear = (state == START) && shift_enable;
    assign cnt_en    = (state == DATA) && shift_enable;

    flex_counter #(
        .WIDTH (CW)
    ) u_bit_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (cnt_clear),
        .count_enable  (cnt_en),
        .rollover_val  (LAST_BIT),
        .rollover_flag (last_bit)
    );

    assign load_ready = (state == IDLE);
    assign busy       = !load_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            serial_out <= IDLE_LINE;
            frame_done <= 1'b0;
            shift_reg  <= '0;
            parity     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    // Ticks are ignored here; a load always wins.
                    if (load_valid) begin
                        shift_reg  <= parallel_in;
                        parity     <= (^parallel_in) ^ ODD_BIT;
                        serial_out <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (shift_enable) begin
                        serial_out <= first_bit;
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (shift_enable) begin
                        if (last_bit) begin
                            if (PARITY_EN != 0) begin
                                serial_out <= parity;
                                state      <= PARITY;
                            end else begin
                                serial_out <= IDLE_LINE;
                                state      <= STOP;
                            end
                        end else begin
                            shift_reg  <= shifted;
                            serial_out <= next_bit;
                        end
                    end
                end
                PARITY: begin
                    if (shift_enable) begin
                        serial_out <= IDLE_LINE;
                        state      <= STOP;
                    end
                end
                STOP: begin
                    if (shift_enable) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    serial_out <= IDLE_LINE;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flex_pts_tx.sv
// Bench for flex_pts_tx: three configurations side by side
//   0: LSB-first, even parity
//   1: MSB-first, no parity
//   2: MSB-first, odd parity
// Expected frame bits come from a positional model of the frame layout.
module tb_flex_pts_tx;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       shift_enable = 1'b0;
    logic       lv [3];
    logic [7:0] pi [3];
    logic       lr [3];
    logic       so [3];
    logic       bz [3];
    logic       fd [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    flex_pts_tx #(.NUM_BITS(8), .SHIFT_MSB(0), .PARITY_EN(1), .PARITY_ODD(0)) dut_a (
        .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable),
        .load_valid(lv[0]), .load_ready(lr[0]), .parallel_in(pi[0]),
        .serial_out(so[0]), .busy(bz[0]), .frame_done(fd[0]));

    flex_pts_tx #(.NUM_BITS(8), .SHIFT_MSB(1), .PARITY_EN(0), .PARITY_ODD(0)) dut_b (
        .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable),
        .load_valid(lv[1]), .load_ready(lr[1]), .parallel_in(pi[1]),
        .serial_out(so[1]), .busy(bz[1]), .frame_done(fd[1]));

    flex_pts_tx #(.NUM_BITS(8), .SHIFT_MSB(1), .PARITY_EN(1), .PARITY_ODD(1)) dut_c (
        .clk(clk), .n_rst(n_rst), .shift_enable(shift_enable),
        .load_valid(lv[2]), .load_ready(lr[2]), .parallel_in(pi[2]),
        .serial_out(so[2]), .busy(bz[2]), .frame_done(fd[2]));

    task automatic chk(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %b expected %b", tag, $time, got, exp);
    endtask

    function automatic logic cfg_msb(input int d); return d != 0; endfunction
    function automatic logic cfg_pen(input int d); return d != 1; endfunction
    function automatic logic cfg_odd(input int d); return d == 2; endfunction
    function automatic int frame_len(input int d); return 10 + int'(cfg_pen(d)); endfunction

    // Bit at position idx of the frame: 0 = start, 1..8 = data,
    // then parity (if enabled), then stop.
    function automatic logic frame_bit(input int d, input logic [7:0] w, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return cfg_msb(d) ? w[8-idx] : w[idx-1];
        if (cfg_pen(d) && idx == 9) return (^w) ^ cfg_odd(d);
        return 1'b1;
    endfunction

    task automatic load_word(input int d, input logic [7:0] w);
        @(negedge clk);
        lv[d] = 1'b1;
        pi[d] = w;
        @(posedge clk); #1;
        chk("start_bit", so[d], 1'b0);
        chk("busy_on_load", bz[d], 1'b1);
        chk("ready_low_on_load", lr[d], 1'b0);
        lv[d] = 1'b0;
    endtask

    // Ticks the frame through; optional stall or reset after tick number
    // stall_at / abort_at. Ends #1 after the final tick edge.
    task automatic run_frame(input int d, input logic [7:0] w,
                             input int stall_at, input int abort_at, input int max_gap);
        int len;
        len = frame_len(d);
        for (int t = 1; t <= len; t++) begin
            @(negedge clk);
            shift_enable = 1'b1;
            @(posedge clk); #1;
            shift_enable = 1'b0;
            if (t < len) begin
                chk("frame_bit", so[d], frame_bit(d, w, t));
                chk("no_early_done", fd[d], 1'b0);
                chk("busy_in_frame", bz[d], 1'b1);
            end else begin
                chk("done_pulse", fd[d], 1'b1);
                chk("stop_line", so[d], 1'b1);
                chk("ready_at_done", lr[d], 1'b1);
            end
            if (t == abort_at) begin
                #3;
                n_rst = 1'b0;
                #1;
                chk("rst_line_high", so[d], 1'b1);
                chk("rst_busy_low", bz[d], 1'b0);
                chk("rst_no_done", fd[d], 1'b0);
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("rst_hold_no_done", fd[d], 1'b0);
                    chk("rst_hold_line", so[d], 1'b1);
                end
                return;
            end
            if (t == stall_at) begin
                @(negedge clk);
                lv[d] = 1'b1;
                pi[d] = 8'hFF;
                @(posedge clk); #1;
                lv[d] = 1'b0;
                chk("busy_load_ignored", lr[d], 1'b0);
                repeat (49) begin
                    @(posedge clk); #1;
                    chk("stall_hold", so[d], frame_bit(d, w, t));
                    chk("stall_not_ready", lr[d], 1'b0);
                end
            end else if (t < len) begin
                repeat ($urandom_range(0, max_gap)) begin
                    @(posedge clk); #1;
                    chk("gap_hold", so[d], frame_bit(d, w, t));
                end
            end
        end
    endtask

    task automatic idle_check(input int d, input int n);
        repeat (n) begin
            @(posedge clk); #1;
            chk("idle_no_done", fd[d], 1'b0);
            chk("idle_line", so[d], 1'b1);
            chk("idle_ready", lr[d], 1'b1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] w;
        int d;
        for (int i = 0; i < 3; i++) begin
            lv[i] = 1'b0;
            pi[i] = 8'h00;
        end
        #2 n_rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_line", so[i], 1'b1);
            chk("reset_busy", bz[i], 1'b0);
            chk("reset_ready", lr[i], 1'b1);
            chk("reset_done", fd[i], 1'b0);
        end
        @(negedge clk);
        n_rst = 1'b1;

        load_word(0, 8'h01);
        run_frame(0, 8'h01, -1, -1, 0);
        idle_check(0, 2);

        load_word(1, 8'h01);
        run_frame(1, 8'h01, -1, -1, 0);
        idle_check(1, 2);

        load_word(2, 8'hA5);
        run_frame(2, 8'hA5, -1, -1, 0);
        idle_check(2, 1);
        load_word(2, 8'h01);
        run_frame(2, 8'h01, -1, -1, 0);
        idle_check(2, 1);

        // Back-to-back with load_valid held high across both frames.
        @(negedge clk);
        lv[1] = 1'b1;
        pi[1] = 8'h55;
        @(posedge clk); #1;
        chk("b2b_first_start", so[1], 1'b0);
        run_frame(1, 8'h55, -1, -1, 1);
        pi[1] = 8'hAA;
        @(posedge clk); #1;
        chk("b2b_second_start", so[1], 1'b0);
        chk("b2b_second_busy", bz[1], 1'b1);
        lv[1] = 1'b0;
        run_frame(1, 8'hAA, -1, -1, 1);
        idle_check(1, 3);

        // Load attempt and long stall mid-data.
        load_word(1, 8'h5A);
        run_frame(1, 8'h5A, 3, -1, 0);
        idle_check(1, 4);

        // Reset after the third data bit, then a clean frame.
        load_word(1, 8'hC3);
        run_frame(1, 8'hC3, -1, 3, 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", lr[1], 1'b1);
        load_word(1, 8'h3C);
        run_frame(1, 8'h3C, -1, -1, 0);
        idle_check(1, 2);

        repeat (24) begin
            d = $urandom_range(0, 2);
            w = 8'($urandom);
            load_word(d, w);
            run_frame(d, w, -1, -1, 2);
            idle_check(d, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
